// File: rtl/sm3_multiblock_hash_if.sv
// Bus between a requester and sm3_multiblock_hash. The custom-IV inputs exist
// only when SM3_CUSTOM_IV_EN is defined.
interface sm3_multiblock_hash_if #(
    parameter int MAX_BLOCKS = 4,
    parameter int CNT_W      = 3
);
    logic                        start;
    logic [MAX_BLOCKS*512-1:0]   msg_in;
    logic [CNT_W-1:0]            num_blocks;
`ifdef SM3_CUSTOM_IV_EN
    logic [255:0]                iv_in;
    logic [0:0]                  use_iv;
`endif
    logic                        busy;
    logic                        done;
    logic                        err;
    logic [CNT_W-1:0]            blk_idx;
    logic [255:0]                hash_value;

    modport master (
        output start, msg_in, num_blocks,
`ifdef SM3_CUSTOM_IV_EN
        output iv_in, use_iv,
`endif
        input  busy, done, err, blk_idx, hash_value
    );

    modport slave (
        input  start, msg_in, num_blocks,
`ifdef SM3_CUSTOM_IV_EN
        input  iv_in, use_iv,
`endif
        output busy, done, err, blk_idx, hash_value
    );
endinterface

// File: rtl/sm3_multiblock_hash.sv
// Multi-block SM3 hasher: chains 1..MAX_BLOCKS pre-padded blocks through one
// iterative sm3_CF core. Optional macro SM3_CUSTOM_IV_EN adds a caller-supplied IV.
module sm3_CF (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [255:0] i_iv,
    input  logic [511:0] i_block,
    output logic         o_end,
    output logic [255:0] o_hash
);
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    logic              r_busy, r_end;
    logic [5:0]        r_round;
    logic [255:0]      r_v, r_hash;
    logic [7:0][31:0]  r_s;
    logic [15:0][31:0] r_w;   // sliding window: r_w[0] = W[j]

    logic [31:0] w_t, w_a12, w_ss1, w_ss2, w_ff, w_gg, w_tt1, w_tt2, w_wnew, w_p0, w_p1in;
    logic [255:0] w_next;

    always_comb begin
        w_t    = (r_round < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
        w_a12  = rotl(r_s[7], 5'd12);
        w_ss1  = rotl(w_a12 + r_s[3] + rotl(w_t, r_round[4:0]), 5'd7);
        w_ss2  = w_ss1 ^ w_a12;
        w_ff   = (r_round < 6'd16) ? (r_s[7] ^ r_s[6] ^ r_s[5])
               : ((r_s[7] & r_s[6]) | (r_s[7] & r_s[5]) | (r_s[6] & r_s[5]));
        w_gg   = (r_round < 6'd16) ? (r_s[3] ^ r_s[2] ^ r_s[1])
               : ((r_s[3] & r_s[2]) | (~r_s[3] & r_s[1]));
        w_tt1  = w_ff + r_s[4] + w_ss2 + (r_w[0] ^ r_w[4]);
        w_tt2  = w_gg + r_s[0] + w_ss1 + r_w[0];
        w_p0   = w_tt2 ^ rotl(w_tt2, 5'd9) ^ rotl(w_tt2, 5'd17);
        w_next = {w_tt1, r_s[7], rotl(r_s[6], 5'd9), r_s[5],
                  w_p0, r_s[3], rotl(r_s[2], 5'd19), r_s[1]};
        w_p1in = r_w[0] ^ r_w[7] ^ rotl(r_w[13], 5'd15);
        w_wnew = w_p1in ^ rotl(w_p1in, 5'd15) ^ rotl(w_p1in, 5'd23)
               ^ rotl(r_w[3], 5'd7) ^ r_w[10];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0; r_end <= 1'b0; r_round <= '0;
            r_v <= '0; r_hash <= '0; r_s <= '0; r_w <= '0;
        end else begin
            r_end <= 1'b0;
            if (r_busy) begin
                r_s     <= w_next;
                r_w     <= {w_wnew, r_w[15:1]};
                r_round <= r_round + 6'd1;
                if (r_round == 6'd63) begin
                    r_busy <= 1'b0;
                    r_end  <= 1'b1;
                    r_hash <= r_v ^ w_next;
                end
            end else if (i_start && !r_end) begin
                // start is still high in the cycle end is seen; r_end blocks a relaunch
                r_busy  <= 1'b1;
                r_round <= '0;
                r_v     <= i_iv;
                r_s     <= i_iv;
                for (int i = 0; i < 16; i++) r_w[i] <= i_block[511-32*i -: 32];
            end
        end
    end

    assign o_end  = r_end;
    assign o_hash = r_hash;
endmodule

module sm3_multiblock_hash #(
    parameter int MAX_BLOCKS = 4,
    parameter int CNT_W      = 3
) (
    input  logic clk,
    input  logic reset,
    sm3_multiblock_hash_if.slave bus
);
    localparam logic [255:0] SM3_IV =
        256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BLOCKS);
    localparam int IDX_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, WAIT, FIN, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [0:MAX_BLOCKS-1][511:0] r_msg;   // element 0 is the most significant block
    logic [CNT_W-1:0]             r_num, r_blk_idx;
    logic [255:0]                 r_civ, r_hash;
    logic                         r_cf_start, r_busy, r_done, r_err;
    logic                         w_cf_end, w_accept, w_bad, w_last;
    logic [255:0]                 w_cf_hash, w_iv0;
    logic [511:0]                 w_block;

`ifdef SM3_CUSTOM_IV_EN
    assign w_iv0 = bus.use_iv[0] ? bus.iv_in : SM3_IV;
`else
    assign w_iv0 = SM3_IV;
`endif
    assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_bad    = (r_num == '0) || (r_num > MAXB);
    assign w_last   = (r_blk_idx == r_num - 1'b1);
    assign w_block  = r_msg[r_blk_idx[IDX_W-1:0]];

    sm3_CF u_cf (
        .clk(clk), .reset(reset), .i_start(r_cf_start), .i_iv(r_civ),
        .i_block(w_block), .o_end(w_cf_end), .o_hash(w_cf_hash)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (bus.start) w_state_nxt = CHECK;
            CHECK:      w_state_nxt = w_bad ? FIN : RUN;
            RUN:        w_state_nxt = WAIT;
            WAIT:       if (w_cf_end) w_state_nxt = w_last ? FIN : RUN;
            FIN:        w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg <= '0; r_num <= '0; r_blk_idx <= '0; r_civ <= SM3_IV; r_hash <= '0;
            r_cf_start <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_msg     <= bus.msg_in;
                r_num     <= bus.num_blocks;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_busy    <= 1'b1;
                r_blk_idx <= '0;
                r_civ     <= w_iv0;
            end
            case (r_state)
                CHECK: if (w_bad) begin
                    // no block has run yet, so r_civ still holds the initial IV
                    r_err  <= 1'b1;
                    r_hash <= r_civ;
                end
                RUN:  r_cf_start <= 1'b1;
                WAIT: if (w_cf_end) begin
                    r_cf_start <= 1'b0;
                    r_civ      <= w_cf_hash;
                    if (!w_last) r_blk_idx <= r_blk_idx + 1'b1;
                end
                FIN: begin
                    if (!r_err) r_hash <= r_civ;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.blk_idx    = r_blk_idx;
    assign bus.hash_value = r_hash;
endmodule

// File: tb/tb_sm3_multiblock_hash.sv
// Directed bench for sm3_multiblock_hash: known-answer digests, length errors,
// busy-start rejection, mid-run reset and back-to-back restart.
module tb_sm3_multiblock_hash;
    localparam logic [255:0] IV  = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    localparam logic [255:0] ABC = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
    localparam logic [255:0] TWO = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

    logic clk = 1'b0;
    logic reset;
    int nvec = 0, nmis = 0;
    logic [2047:0] m_abc, m_two;

    sm3_multiblock_hash_if #(.MAX_BLOCKS(4), .CNT_W(3)) bus();
    sm3_multiblock_hash #(.MAX_BLOCKS(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic launch(input logic [2047:0] m, input logic [2:0] n);
        bus.msg_in = m; bus.num_blocks = n; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.msg_in = '0; bus.num_blocks = '0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!bus.done && k < 2000) begin @(posedge clk); #1; k++; end
        nvec++;
        if (!bus.done) begin nmis++; $display("FAIL %s timeout: done=%b required 1", nm, bus.done); end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.start = 1'b0; bus.msg_in = '0; bus.num_blocks = '0;
`ifdef SM3_CUSTOM_IV_EN
        bus.iv_in = '0; bus.use_iv = 1'b0;
`endif
        repeat (2) @(posedge clk); #1;
        nvec += 5;
        if (bus.busy !== 1'b0) begin nmis++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin nmis++; $display("FAIL rst_done got %b want 0", bus.done); end
        if (bus.err !== 1'b0) begin nmis++; $display("FAIL rst_err got %b want 0", bus.err); end
        if (bus.blk_idx !== 3'd0) begin nmis++; $display("FAIL rst_idx got %0d want 0", bus.blk_idx); end
        if (bus.hash_value !== 256'h0) begin nmis++; $display("FAIL rst_hash got %h want 0", bus.hash_value); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc(input string nm);
        launch(m_abc, 3'd1);
        nvec++;
        if (bus.busy !== 1'b1) begin nmis++; $display("FAIL %s_busy got %b want 1", nm, bus.busy); end
        wait_done(nm);
        nvec += 2;
        if (bus.err !== 1'b0) begin nmis++; $display("FAIL %s_err got %b want 0", nm, bus.err); end
        if (bus.hash_value !== ABC) begin nmis++; $display("FAIL %s_hash got %h want %h", nm, bus.hash_value, ABC); end
    endtask

    task automatic test_two_block();
        int gap, lowcnt, k, idx_hi[2], nhi;
        bit seen_hi;
        gap = -1; lowcnt = 0; nhi = 0; seen_hi = 0; k = 0;
        idx_hi[0] = -1; idx_hi[1] = -1;
        launch(m_two, 3'd2);
        while (!bus.done && k < 2000) begin
            if (dut.r_cf_start) begin
                if (!seen_hi || lowcnt > 0) begin
                    if (nhi < 2) idx_hi[nhi] = int'(bus.blk_idx);
                    if (seen_hi && gap < 0) gap = lowcnt;
                    nhi++;
                end
                seen_hi = 1; lowcnt = 0;
            end else if (seen_hi) lowcnt++;
            @(posedge clk); #1; k++;
        end
        nvec += 5;
        if (!bus.done) begin nmis++; $display("FAIL two_timeout done=%b want 1", bus.done); end
        if (bus.hash_value !== TWO) begin nmis++; $display("FAIL two_hash got %h want %h", bus.hash_value, TWO); end
        if (gap != 1) begin nmis++; $display("FAIL two_gap got %0d want 1", gap); end
        if (idx_hi[0] != 0) begin nmis++; $display("FAIL two_idx0 got %0d want 0", idx_hi[0]); end
        if (idx_hi[1] != 1) begin nmis++; $display("FAIL two_idx1 got %0d want 1", idx_hi[1]); end
    endtask

    task automatic test_len_err(input logic [2:0] n);
        launch(m_abc, n);
        @(posedge clk); #1;
        nvec++;
        if (bus.done !== 1'b0) begin nmis++; $display("FAIL err%0d_early done=%b want 0", n, bus.done); end
        @(posedge clk); #1;
        nvec += 3;
        if (bus.done !== 1'b1) begin nmis++; $display("FAIL err%0d_done got %b want 1", n, bus.done); end
        if (bus.err !== 1'b1) begin nmis++; $display("FAIL err%0d_err got %b want 1", n, bus.err); end
        if (bus.hash_value !== IV) begin nmis++; $display("FAIL err%0d_hash got %h want %h", n, bus.hash_value, IV); end
    endtask

    task automatic test_busy_start();
        int k;
        k = 0;
        launch(m_two, 3'd2);
        while (bus.blk_idx != 3'd1 && k < 2000) begin @(posedge clk); #1; k++; end
        bus.msg_in = m_abc; bus.num_blocks = 3'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("busy_start");
        nvec += 2;
        if (bus.err !== 1'b0) begin nmis++; $display("FAIL busy_start_err got %b want 0", bus.err); end
        if (bus.hash_value !== TWO) begin nmis++; $display("FAIL busy_start_hash got %h want %h", bus.hash_value, TWO); end
    endtask

    task automatic test_mid_reset();
        int k;
        k = 0;
        launch(m_two, 3'd2);
        while (bus.blk_idx != 3'd1 && k < 2000) begin @(posedge clk); #1; k++; end
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        nvec += 4;
        if (bus.busy !== 1'b0) begin nmis++; $display("FAIL mrst_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin nmis++; $display("FAIL mrst_done got %b want 0", bus.done); end
        if (bus.blk_idx !== 3'd0) begin nmis++; $display("FAIL mrst_idx got %0d want 0", bus.blk_idx); end
        if (bus.hash_value !== 256'h0) begin nmis++; $display("FAIL mrst_hash got %h want 0", bus.hash_value); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        test_abc("after_rst");
    endtask

    task automatic test_back_to_back();
        launch(m_abc, 3'd1);
        nvec += 2;
        if (bus.done !== 1'b0) begin nmis++; $display("FAIL b2b_done_drop got %b want 0", bus.done); end
        if (bus.busy !== 1'b1) begin nmis++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
        wait_done("b2b");
        nvec++;
        if (bus.hash_value !== ABC) begin nmis++; $display("FAIL b2b_hash got %h want %h", bus.hash_value, ABC); end
    endtask

    initial begin
        m_abc = '0;
        m_abc[2047 -: 32] = 32'h61626380;
        m_abc[1567 -: 32] = 32'h00000018;
        m_two = '0;
        for (int i = 0; i < 16; i++) m_two[2047-32*i -: 32] = 32'h61626364;
        m_two[1535 -: 32] = 32'h80000000;
        m_two[1055 -: 32] = 32'h00000200;

        test_reset();
        test_abc("abc");
        test_two_block();
        test_len_err(3'd0);
        test_len_err(3'd5);
        test_busy_start();
        test_mid_reset();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
